servo_pwm_bank: RTL and testbench

//  Parametrised N-channel servo/ESC PWM generator; generalises the fixed 3-output launcher PWM block.

---
 rtl/servo_pwm_bank_pkg.sv | 30 +++
 rtl/servo_pwm_bank_chan.sv | 69 ++++++
 rtl/servo_pwm_bank.sv | 143 ++++++++++++++
 tb/tb_servo_pwm_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_bank_pkg.sv
// rtl/servo_pwm_bank_pkg.sv - shared types and elaboration helpers for servo_pwm_bank
// Purpose: command FSM state encoding, clog2 helper and pulse scale factor.
// Ports: none (package).
package servo_pwm_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_WRITE = 2'd2
  } cmd_state_e;

  // Bits needed to hold values 0..v-1 (minimum 0).
  function automatic int clog2_f(input int v);
    int    r;
    longint p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p * 2;
      r++;
    end
    return r;
  endfunction

  // Cycles of pulse width per command LSB.
  function automatic int scale_f(input int min_pulse, input int max_pulse, input int cmd_w);
    return (max_pulse - min_pulse) / ((1 << cmd_w) - 1);
  endfunction

endpackage

// File: rtl/servo_pwm_bank_chan.sv
// rtl/servo_pwm_bank_chan.sv - one PWM channel: target/current width, slew, compare, busy
// Purpose: holds the commanded target and the width actually in use; the in-use width
//          only moves on the frame's last cycle so every pulse is a whole, unglitched one.
// Ports: clock, reset        clock and asynchronous active-high reset
//        enable              0 forces pwm_out low on the next cycle
//        count               shared frame counter
//        slew_cycle          high on the last cycle of the frame
//        wr_en, wr_val       new target from the command path
//        pwm_out, busy       registered PWM output and (cur != target) flag
module servo_pwm_bank_chan #(
  parameter int W         = 20,
  parameter int MIN_PULSE = 50000,
  parameter int SLEW_STEP = 500
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] count,
  input  logic         slew_cycle,
  input  logic         wr_en,
  input  logic [W-1:0] wr_val,
  output logic         pwm_out,
  output logic         busy
);

  logic [W-1:0] tgt_q;
  logic [W-1:0] cur_q;
  logic [W-1:0] cur_d;
  logic [W-1:0] diff;
  logic         pwm_q;
  logic         busy_q;

  // Step toward the target, landing exactly on it when within one step.
  always_comb begin
    cur_d = cur_q;
    diff  = '0;
    if (tgt_q > cur_q) begin
      diff  = tgt_q - cur_q;
      cur_d = (SLEW_STEP == 0 || diff <= W'(SLEW_STEP)) ? tgt_q : cur_q + W'(SLEW_STEP);
    end else if (tgt_q < cur_q) begin
      diff  = cur_q - tgt_q;
      cur_d = (SLEW_STEP == 0 || diff <= W'(SLEW_STEP)) ? tgt_q : cur_q - W'(SLEW_STEP);
    end
  end

  // A write landing on the slew cycle is stored but the slew above still used the
  // old target, so it takes effect one frame later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tgt_q  <= W'(MIN_PULSE);
      cur_q  <= W'(MIN_PULSE);
      pwm_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (wr_en) begin
        tgt_q <= wr_val;
      end
      if (slew_cycle) begin
        cur_q <= cur_d;
      end
      pwm_q  <= enable && (count < cur_q);
      busy_q <= (cur_q != tgt_q);
    end
  end

  assign pwm_out = pwm_q;
  assign busy    = busy_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - N-channel servo/ESC PWM generator with slew-limited widths
// Purpose: free-running frame counter, valid/ready command path that scales a command
//          to a pulse width, and NUM_CH slew-limited PWM channels.
// Ports: clock, reset             clock and asynchronous active-high reset
//        enable                  0 forces all pwm_out low
//        cmd_valid, cmd_ready    command handshake
//        cmd_ch, cmd_value       target channel and position/throttle command
//        cmd_err                 1-cycle pulse when an accepted command named a missing channel
//        pwm_out, busy           per-channel PWM output and slewing flag
//        frame_start             1-cycle pulse after the counter was observed at 0
module servo_pwm_bank
  import servo_pwm_bank_pkg::*;
#(
  parameter int  NUM_CH     = 3,
  parameter int  PERIOD_CYC = 1000000,
  parameter int  MIN_PULSE  = 50000,
  parameter int  MAX_PULSE  = 100000,
  parameter int  CMD_W      = 8,
  parameter int  SLEW_STEP  = 500,
  localparam int CH_W       = (NUM_CH > 1) ? clog2_f(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CMD_W-1:0]  cmd_value,
  output logic              cmd_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] busy,
  output logic              frame_start
);

  localparam int CNT_W  = clog2_f(PERIOD_CYC);
  localparam int SCALE  = scale_f(MIN_PULSE, MAX_PULSE, CMD_W);
  localparam int PROD_W = CMD_W + clog2_f(SCALE + 1);

  logic [CNT_W-1:0]  count_q;
  logic              frame_start_q;
  logic              slew_cycle;

  cmd_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CMD_W-1:0]  value_q, value_d;
  logic [CNT_W-1:0]  tgt_calc_q, tgt_calc_d;
  logic [PROD_W-1:0] product;

  assign slew_cycle = (count_q == CNT_W'(PERIOD_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= slew_cycle ? '0 : count_q + 1'b1;
      frame_start_q <= (count_q == '0);
    end
  end

  assign product = PROD_W'(value_q) * PROD_W'(SCALE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ch_q        <= '0;
      value_q     <= '0;
      tgt_calc_q  <= CNT_W'(MIN_PULSE);
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      ch_q        <= ch_d;
      value_q     <= value_d;
      tgt_calc_q  <= tgt_calc_d;
    end
  end

  // cmd_ready is registered: it reflects the state the FSM enters on this edge,
  // which also makes it rise on the first clock after reset.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cmd_err_d   = 1'b0;
    ch_d        = ch_q;
    value_d     = value_q;
    tgt_calc_d  = tgt_calc_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_SCALE;
          cmd_ready_d = 1'b0;
          ch_d        = cmd_ch;
          value_d     = cmd_value;
        end
      end
      ST_SCALE: begin
        tgt_calc_d = CNT_W'(MIN_PULSE) + CNT_W'(product);
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        cmd_err_d   = ({1'b0, ch_q} >= (CH_W + 1)'(NUM_CH));
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = (state_q == ST_WRITE) && (ch_q == CH_W'(i));

    servo_pwm_bank_chan #(
      .W         (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .SLEW_STEP (SLEW_STEP)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .count      (count_q),
      .slew_cycle (slew_cycle),
      .wr_en      (wr_en),
      .wr_val     (tgt_calc_q),
      .pwm_out    (pwm_out[i]),
      .busy       (busy[i])
    );
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_err     = cmd_err_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - self-checking bench for servo_pwm_bank (jump and slew-limited instances)
module tb_servo_pwm_bank;

  localparam int P   = 1000;
  localparam int NCH = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [3:0] cmd_value = '0;

  logic       rdy_a, err_a, fs_a, rdy_b, err_b, fs_b;
  logic [2:0] pwm_a, busy_a, pwm_b, busy_b;

  servo_pwm_bank #(
    .NUM_CH(NCH), .PERIOD_CYC(P), .MIN_PULSE(50), .MAX_PULSE(100), .CMD_W(4), .SLEW_STEP(0)
  ) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(rdy_a),
    .cmd_ch(cmd_ch), .cmd_value(cmd_value), .cmd_err(err_a), .pwm_out(pwm_a), .busy(busy_a),
    .frame_start(fs_a)
  );

  servo_pwm_bank #(
    .NUM_CH(NCH), .PERIOD_CYC(P), .MIN_PULSE(50), .MAX_PULSE(100), .CMD_W(4), .SLEW_STEP(10)
  ) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(rdy_b),
    .cmd_ch(cmd_ch), .cmd_value(cmd_value), .cmd_err(err_b), .pwm_out(pwm_b), .busy(busy_b),
    .frame_start(fs_b)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: index 0 = instance without slew limit, 1 = SLEW_STEP 10.
  int slew_of[2] = '{0, 10};
  int cur_m[2][NCH];
  int tgt_m[2][NCH];
  int n;          // clock edges since reset release; frame position is n % P
  int ph;         // edges left until the accepted command is written
  int lch, lval;
  bit rdy_m;
  bit acc_last;
  int hi_a[NCH], hi_b[NCH], last_wa[NCH], last_wb[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int slew(input int c, input int t, input int s);
    int d;
    d = (t > c) ? t - c : c - t;
    if (s == 0 || d <= s) return t;
    return (t > c) ? c + s : c - s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        cur_m[d][i] = 50;
        tgt_m[d][i] = 50;
      end
    n = 0; ph = 0; rdy_m = 0; acc_last = 0;
    for (int i = 0; i < NCH; i++) begin
      hi_a[i] = 0; hi_b[i] = 0; last_wa[i] = 0; last_wb[i] = 0;
    end
  endtask

  task automatic tick();
    int         cnt;
    bit         acc, err_e, fs_e;
    logic [2:0] pwm_e[2], busy_e[2];
    logic [8:0] exp_a, exp_b;
    cnt = n % P;
    acc = cmd_valid && rdy_m;
    fs_e = (cnt == 0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        pwm_e[d][i]  = enable && (cnt < cur_m[d][i]);
        busy_e[d][i] = (cur_m[d][i] != tgt_m[d][i]);
      end
    @(posedge clock);
    #1;
    n++;
    if (cnt == P - 1)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NCH; i++)
          cur_m[d][i] = slew(cur_m[d][i], tgt_m[d][i], slew_of[d]);
    err_e = 0;
    acc_last = 0;
    if (ph > 0) begin
      ph--;
      if (ph == 0) begin
        if (lch < NCH) begin
          tgt_m[0][lch] = 50 + 3 * lval;
          tgt_m[1][lch] = 50 + 3 * lval;
        end else err_e = 1;
      end
    end else if (acc) begin
      lch = int'(cmd_ch);
      lval = int'(cmd_value);
      ph = 2;
      acc_last = 1;
    end
    rdy_m = (ph == 0);
    exp_a = {pwm_e[0], busy_e[0], fs_e, rdy_m, err_e};
    exp_b = {pwm_e[1], busy_e[1], fs_e, rdy_m, err_e};
    check("cycle_a", 32'({pwm_a, busy_a, fs_a, rdy_a, err_a}), 32'(exp_a));
    check("cycle_b", 32'({pwm_b, busy_b, fs_b, rdy_b, err_b}), 32'(exp_b));
    for (int i = 0; i < NCH; i++) begin
      hi_a[i] += int'(pwm_a[i]);
      hi_b[i] += int'(pwm_b[i]);
    end
    if (n % P == 0)
      for (int i = 0; i < NCH; i++) begin
        last_wa[i] = hi_a[i]; last_wb[i] = hi_b[i];
        hi_a[i] = 0; hi_b[i] = 0;
      end
  endtask

  task automatic run_frame_end();
    tick();
    while (n % P != 0) tick();
  endtask

  task automatic run_to(input int c);
    while (n % P != c) tick();
  endtask

  task automatic send_cmd(input int ch, input int val);
    int k;
    cmd_valid = 1'b1;
    cmd_ch = 2'(ch);
    cmd_value = 4'(val);
    k = 0;
    tick();
    while (!acc_last && k < 10) begin
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    check("accept_ready_drop", 32'(rdy_a), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_pwm", 32'({pwm_a, pwm_b}), 32'd0);
    check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    check("rst_ready", 32'({rdy_a, rdy_b}), 32'd0);
    check("rst_err", 32'({err_a, err_b}), 32'd0);
    check("rst_fs", 32'({fs_a, fs_b}), 32'd0);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    enable = 1'b1;
    #2;
    check_reset_values();
    release_reset();
    tick();
    check("ready_after_reset", 32'(rdy_a), 32'd1);

    // 1: idle widths are MIN_PULSE on every channel
    while (n % P != 0) tick();
    run_frame_end();
    for (int i = 0; i < NCH; i++) check("idle_width", 32'(last_wa[i]), 32'd50);

    // 2: ch1 value 15 -> 95 cycles from the next frame
    send_cmd(1, 15);
    tick();
    check("ready_low_2nd", 32'(rdy_a), 32'd0);
    tick();
    check("ready_back", 32'(rdy_a), 32'd1);
    run_frame_end();
    run_frame_end();
    check("w_ch1_95", 32'(last_wa[1]), 32'd95);
    check("w_ch0_50", 32'(last_wa[0]), 32'd50);
    check("w_ch2_50", 32'(last_wa[2]), 32'd50);

    // 3: slew-limited ch0 to 80 -> 60, 70, 80
    send_cmd(0, 10);
    run_frame_end();
    run_frame_end();
    check("slew_60", 32'(last_wb[0]), 32'd60);
    check("jump_80", 32'(last_wa[0]), 32'd80);
    repeat (5) tick();
    check("slew_busy", 32'(busy_b[0]), 32'd1);
    run_frame_end();
    check("slew_70", 32'(last_wb[0]), 32'd70);
    run_frame_end();
    check("slew_80", 32'(last_wb[0]), 32'd80);
    repeat (5) tick();
    check("slew_done", 32'(busy_b[0]), 32'd0);

    // 4: out-of-range channel
    send_cmd(3, 5);
    tick();
    check("err_not_yet", 32'(err_a), 32'd0);
    tick();
    check("err_pulse", 32'(err_a), 32'd1);
    tick();
    check("err_single", 32'(err_a), 32'd0);
    run_frame_end();
    run_frame_end();
    check("err_nowrite", 32'({last_wa[0], last_wa[1], last_wa[2]}), 32'({32'd80, 32'd95, 32'd50}));

    // 5: WRITE lands on the slew cycle
    run_to(997);
    send_cmd(2, 5);
    tick();
    tick();
    check("write_on_boundary", 32'(n % P), 32'd0);
    run_frame_end();
    check("boundary_old_w", 32'(last_wa[2]), 32'd50);
    run_frame_end();
    check("boundary_new_w", 32'(last_wa[2]), 32'd65);

    // randomized commands, valid held across busy cycles, enable toggling
    for (int k = 0; k < 40; k++) begin
      int idle;
      idle = $urandom_range(0, 300);
      for (int j = 0; j < idle; j++) begin
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        tick();
      end
      send_cmd($urandom_range(0, 3), $urandom_range(0, 15));
    end
    enable = 1'b1;
    run_frame_end();
    run_frame_end();

    // 6: enable low mid-pulse, then reset mid-SCALE
    run_to(20);
    enable = 1'b0;
    tick();
    check("enable_off", 32'(pwm_a), 32'd0);
    run_to(100);
    enable = 1'b1;
    send_cmd(0, 0);
    reset = 1'b1;
    #1;
    check_reset_values();
    release_reset();
    run_frame_end();
    run_frame_end();
    for (int i = 0; i < NCH; i++) check("post_reset_w", 32'(last_wa[i]), 32'd50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
